// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular FIFO of {pc, pc+4, instr} with flush on redirect.
// Optional performance counters are compiled in with IF_ID_QUEUE_PERF_EN.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_pc_plus4,
  input  logic [XLEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [XLEN-1:0]            out_instr,
  output logic [$clog2(DEPTH):0]     count
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop;

  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= '{pc: in_pc, pc4: in_pc_plus4, instr: in_instr};
  end

  assign out_pc       = out_valid ? mem_q[rd_q].pc    : '0;
  assign out_pc_plus4 = out_valid ? mem_q[rd_q].pc4   : '0;
  assign out_instr    = out_valid ? mem_q[rd_q].instr : NOP;
  assign count        = cnt_q;

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] stall_q, flush_cnt_q;
  logic [32:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt_q} + 33'(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (flush)
        flush_cnt_q <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
    end
  end

  assign perf_stall_cnt = stall_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: directed scenarios followed by randomized traffic.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
  } trip_t;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic            in_ready, out_valid;
  logic [XLEN-1:0] in_pc, in_pc_plus4, in_instr;
  logic [XLEN-1:0] out_pc, out_pc_plus4, out_instr;
  logic [CW-1:0]   count;
`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0]     perf_stall_cnt, perf_flush_cnt;
  int unsigned     m_stall, m_flush;
`endif

  int     n_checks = 0;
  int     n_pass   = 0;
  trip_t  sb[$];

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_instr(out_instr),
    .count(count)
`ifdef IF_ID_QUEUE_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare outputs against the scoreboard, then account for the transfer
  // the upcoming edge will perform with the inputs now being presented.
  always @(negedge clk) begin
    int sz;
    sz = sb.size();
    check("count", 64'(count), 64'(sz));
    check("out_valid", 64'(out_valid), 64'(sz != 0));
    check("in_ready", 64'(in_ready), 64'(sz != DEPTH));
    if (sz != 0) begin
      check("out_pc", 64'(out_pc), 64'(sb[0].pc));
      check("out_pc_plus4", 64'(out_pc_plus4), 64'(sb[0].pc4));
      check("out_instr", 64'(out_instr), 64'(sb[0].instr));
    end else begin
      check("empty_pc", 64'(out_pc), 64'd0);
      check("empty_instr", 64'(out_instr), 64'h13);
    end
`ifdef IF_ID_QUEUE_PERF_EN
    check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
    check("perf_flush", 64'(perf_flush_cnt), 64'(m_flush));
    if (rst) begin
      m_stall = 0;
      m_flush = 0;
    end else if (flush) m_flush += sz;
    else if (in_valid && sz == DEPTH) m_stall++;
`endif
    if (rst || flush) sb.delete();
    else begin
      if (sz != 0 && out_ready) void'(sb.pop_front());
      if (in_valid && sz != DEPTH) sb.push_back('{in_pc, in_pc_plus4, in_instr});
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                       input logic ordy);
    rst = r; flush = f; in_valid = iv; out_ready = ordy;
    in_pc = pc; in_pc_plus4 = pc + 32'd4; in_instr = ins;
    @(posedge clk); #1;
  endtask

  initial begin
    drive(1, 0, 1, 32'h40, 32'h1, 0);
    drive(1, 0, 1, 32'h44, 32'h2, 0);
    drive(1, 0, 1, 32'h48, 32'h3, 0);
    // single push, hold, single pop
    drive(0, 0, 1, 32'h0, 32'h0050_0093, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    // fill, hold 5th push while full, pop one, then push the 5th
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 32'(i * 4), 32'(32'h1000 + i), 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 32'h10, 32'h1004, 0);
    drive(0, 0, 1, 32'h10, 32'h1004, 1);
    drive(0, 0, 1, 32'h10, 32'h1004, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 32'h0, 32'h0, 1);
    // steady push+pop at count 2
    drive(0, 0, 1, 32'h200, 32'h2000, 0);
    drive(0, 0, 1, 32'h204, 32'h2001, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 32'(32'h208 + 4 * i), 32'(32'h2002 + i), 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 32'h0, 32'h0, 1);
    // flush at count 3 with simultaneous push and pop
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 32'(32'h300 + 4 * i), 32'(32'h3000 + i), 0);
    drive(0, 1, 1, 32'h30C, 32'h3003, 1);
    drive(0, 0, 1, 32'h100, 32'h0010_0013, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 1);
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    // randomized traffic with occasional flush and rare reset
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_pc = $urandom; in_pc_plus4 = $urandom; in_instr = $urandom;
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Buffers fetched {PC, PC+4, instruction} triples in a circular FIFO with valid/ready handshakes on both sides.
- Flushes all buffered entries on a taken branch/jump, so decode never sees wrong-path instructions.
- Lets fetch run ahead while decode stalls; outputs are registered-storage reads with no fall-through path.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 32, width of PC and instruction fields.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  driven by PCSel when a branch is taken; discards all entries.
- in_valid  input  1  fetch presents a valid triple.
- in_ready  output  1  queue can accept a push this cycle.
- in_pc  input  XLEN  PC of the fetched instruction (PC_Out).
- in_pc_plus4  input  XLEN  PC+4 from fetch.
- in_instr  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  XLEN  head PC.
- out_pc_plus4  output  XLEN  head PC+4.
- out_instr  output  XLEN  head instruction.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH. count is a separate register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It depends only on state, never on out_ready, so a full queue cannot push even if popped the same cycle.
- out_valid = (count != 0).
- No bypass: an entry pushed at edge N is visible on out_* after edge N; minimum latency is 1 cycle.
- Empty outputs: out_pc = 0, out_pc_plus4 = 0, out_instr = 32'h00000013 (NOP).
- Valid outputs: the fields at rd_ptr.
- Per clock edge, in priority order:
  1. rst=1: wr_ptr, rd_ptr and count go to 0. Storage contents are don't-care; outputs read as empty values.
  2. flush=1: same as rst for pointers and count. Any push or pop presented that cycle is ignored and not counted as a transfer.
  3. push only: write at wr_ptr, wr_ptr+1, count+1.
  4. pop only: rd_ptr+1, count-1.
  5. push and pop (0 < count < DEPTH): write and advance both pointers; count unchanged.
  6. Neither: hold.
- Wrap-around: pointers roll from DEPTH-1 to 0; FIFO order is preserved across the wrap.
- Empty with out_ready=1: no pop, no state change.
- Reset mid-operation: all entries are lost; out_valid=0 and in_ready=1 from the next cycle.
- Data fields are stored unmodified, with no interpretation of instruction bits.

Optional Feature:
- Macro: IF_ID_QUEUE_PERF_EN.
- Defined: adds two output ports, perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments each cycle with in_valid=1 and in_ready=0 (and flush=0).
  - perf_flush_cnt adds count at each flush edge, i.e. the number of discarded entries.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on rst. Flush does not clear them.
- Not defined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, count=0, out_instr=32'h00000013 during and after reset.
- Single push: in_pc=0x0, in_pc_plus4=0x4, in_instr=0x00500093, out_ready=0 -> next cycle out_valid=1, out_pc=0x0, out_instr=0x00500093, count=1. Then out_ready=1 for one cycle -> count=0.
- Fill/full and wrap, DEPTH=4: push PCs 0x0, 0x4, 0x8, 0xC with out_ready=0 -> count=4, in_ready=0, and a 5th push at 0x10 is held by fetch. Then pop one and push 0x10 -> drain order 0x4, 0x8, 0xC, 0x10 with wrap-correct data.
- Simultaneous push/pop at count=2 for 6 cycles -> count stays 2; output PCs step by 4 each cycle in order.
- Flush: count=3 with flush=1, in_valid=1, out_ready=1 on the same edge -> next cycle count=0, out_valid=0. The pushed entry is not stored; the next push of 0x100 is the head after 1 cycle. With IF_ID_QUEUE_PERF_EN, perf_flush_cnt=3.
- Stall counter (IF_ID_QUEUE_PERF_EN): hold the queue full with in_valid=1 for 5 cycles -> perf_stall_cnt=5. Assert rst -> 0.
